// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields and a 32-bit immediate into an instruction word, checks the immediate, and buffers results in a FIFO
// in_*  : field bundle with valid/ready handshake (in_fmt 0=R 1=I 2=S 3=B 4=U 5=J)
// out_* : FIFO head, encoded word plus error code (0 ok, 1 bad fmt, 2 out of range, 3 misaligned)
// cnt_ok / cnt_err : saturating counts of accepted good / error bundles
module instr_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_fmt,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [1:0]       out_err,
    output logic [CNT_W-1:0] cnt_ok,
    output logic [CNT_W-1:0] cnt_err
);
    localparam int AW = $clog2(DEPTH);
    logic signed [31:0] simm;
    logic               bad, mis, rng;
    logic [1:0]         err;
    logic [31:0]        enc, instr;
    logic [31:0]        mem_instr [DEPTH];
    logic [1:0]         mem_err [DEPTH];
    logic [AW-1:0]      wp, rp;
    logic [AW:0]        cnt;
    logic               rdy, full, empty, push, pop;
    assign simm = in_imm;
    always_comb begin
        bad = in_fmt > 3'd5;
        mis = ((in_fmt == 3'd3 || in_fmt == 3'd5) && in_imm[0]) || (in_fmt == 3'd4 && in_imm[11:0] != 12'd0);
        rng = (in_fmt == 3'd1 || in_fmt == 3'd2) ? (simm < -32'sd2048 || simm > 32'sd2047) :
              (in_fmt == 3'd3) ? (simm < -32'sd4096 || simm > 32'sd4094) :
              (in_fmt == 3'd5) ? (simm < -32'sd1048576 || simm > 32'sd1048574) : 1'b0;
        err = bad ? 2'd1 : mis ? 2'd3 : rng ? 2'd2 : 2'd0;
        enc = (in_fmt == 3'd0) ? {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode} :
              (in_fmt == 3'd1) ? {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode} :
              (in_fmt == 3'd2) ? {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode} :
              (in_fmt == 3'd3) ? {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11], in_opcode} :
              (in_fmt == 3'd4) ? {in_imm[31:12], in_rd, in_opcode} :
                                 {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        instr = (err != 2'd0) ? 32'd0 : enc;
    end
    assign full      = cnt == (AW+1)'(DEPTH);
    assign empty     = cnt == '0;
    // rdy holds in_ready low until the first edge after reset release
    assign in_ready  = rdy && !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_instr = empty ? 32'd0 : mem_instr[rp];
    assign out_err   = empty ? 2'd0 : mem_err[rp];
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wp] <= instr;
            mem_err[wp]   <= err;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp      <= '0;
            rp      <= '0;
            cnt     <= '0;
            rdy     <= 1'b0;
            cnt_ok  <= '0;
            cnt_err <= '0;
        end else begin
            rdy <= 1'b1;
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            if (push && err == 2'd0 && cnt_ok != '1) cnt_ok <= cnt_ok + CNT_W'(1);
            if (push && err != 2'd0 && cnt_err != '1) cnt_err <= cnt_err + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: table-driven and scoreboard checks of instr_encoder
module tb_instr_encoder;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] xi;
        logic [1:0]  xe;
    } vec_t;
    typedef struct {
        logic [31:0] i;
        logic [1:0]  e;
    } exp_t;
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0, in_ready;
    logic [2:0]       in_fmt = '0;
    logic [6:0]       in_opcode = '0;
    logic [4:0]       in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [2:0]       in_funct3 = '0;
    logic [6:0]       in_funct7 = '0;
    logic [31:0]      in_imm = '0;
    logic             out_valid, out_ready = 1'b0;
    logic [31:0]      out_instr;
    logic [1:0]       out_err;
    logic [CNT_W-1:0] cnt_ok, cnt_err;
    int               nvec = 0, nerr = 0;
    int               mok = 0, merr = 0;
    exp_t             q[$];
    exp_t             cur;
    vec_t             tbl[24];

    instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err),
        .cnt_ok(cnt_ok), .cnt_err(cnt_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(logic [2:0] f, logic [6:0] op, logic [4:0] rd, logic [4:0] rs1,
                                logic [4:0] rs2, logic [2:0] f3, logic [6:0] f7, logic [31:0] imm,
                                logic [31:0] xi, logic [1:0] xe);
        vec_t v;
        v.fmt = f; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.f3 = f3; v.f7 = f7; v.imm = imm; v.xi = xi; v.xe = xe;
        return v;
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        nvec++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    task automatic drive(input vec_t v);
        in_fmt = v.fmt; in_opcode = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
        in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
        cur.i = v.xi; cur.e = v.xe;
    endtask

    task automatic drive_i(input int k);
        vec_t v;
        v = mk(3'd1, 7'h13, 5'(k), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k), {12'(k), 5'd0, 3'd0, 5'(k), 7'h13}, 2'd0);
        drive(v);
    endtask

    task automatic step();
        exp_t h;
        bit pu, po;
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < DEPTH});
        chk("cnt_ok", 32'(cnt_ok), 32'(mok));
        chk("cnt_err", 32'(cnt_err), 32'(merr));
        if (q.size() != 0) begin
            chk("out_instr", out_instr, q[0].i);
            chk("out_err", {30'd0, out_err}, {30'd0, q[0].e});
        end
        pu = in_valid && (q.size() < DEPTH);
        po = out_ready && (q.size() != 0);
        if (po) h = q.pop_front();
        if (pu) begin
            q.push_back(cur);
            if (cur.e == 2'd0) mok = (mok == 15) ? 15 : mok + 1;
            else merr = (merr == 15) ? 15 : merr + 1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        tbl[0]  = mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 2'd0);
        tbl[1]  = mk(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020A423, 2'd0);
        tbl[2]  = mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 32'hFE000EE3, 2'd0);
        tbl[3]  = mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h001000EF, 2'd0);
        tbl[4]  = mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 2'd0);
        tbl[5]  = mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0, 2'd3);
        tbl[6]  = mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h0, 2'd2);
        tbl[7]  = mk(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h0, 2'd1);
        tbl[8]  = mk(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0, 32'h002081B3, 2'd0);
        tbl[9]  = mk(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEADBEEF, 32'h402081B3, 2'd0);
        tbl[10] = mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, 32'h80000093, 2'd0);
        tbl[11] = mk(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd2047, 32'h7E20AFA3, 2'd0);
        tbl[12] = mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094, 32'h7E000FE3, 2'd0);
        tbl[13] = mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF000, 32'h80000063, 2'd0);
        tbl[14] = mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF00000, 32'h800000EF, 2'd0);
        tbl[15] = mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h000FFFFE, 32'h7FFFF0EF, 2'd0);
        tbl[16] = mk(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFFF7FF, 32'h0, 2'd2);
        tbl[17] = mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00100000, 32'h0, 2'd2);
        tbl[18] = mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096, 32'h0, 2'd2);
        tbl[19] = mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4097, 32'h0, 2'd3);
        tbl[20] = mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, 32'h0, 2'd3);
        tbl[21] = mk(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h0, 2'd1);
        tbl[22] = mk(3'd7, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0, 2'd1);
        tbl[23] = mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h0, 2'd3);

        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_err", {30'd0, out_err}, 32'd0);
        chk("rst_cnt_ok", 32'(cnt_ok), 32'd0);
        chk("rst_cnt_err", 32'(cnt_err), 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_release", {31'd0, in_ready}, 32'd1);

        out_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            drive(tbl[i]);
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            step();
            if (i == 7) begin
                chk("cnt_ok_after_8", 32'(cnt_ok), 32'd5);
                chk("cnt_err_after_8", 32'(cnt_err), 32'd3);
            end
        end
        step();

        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            drive_i(k);
            in_valid = 1'b1;
            step();
        end
        #1;
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        drive_i(5);
        step();
        step();
        out_ready = 1'b1;
        step();
        for (int k = 5; k <= 10; k++) begin
            drive_i(k);
            step();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("cnt_ok_saturated", 32'(cnt_ok), 32'd15);

        out_ready = 1'b0;
        for (int k = 11; k <= 13; k++) begin
            drive_i(k);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_cnt_ok", 32'(cnt_ok), 32'd0);
        chk("midrst_cnt_err", 32'(cnt_err), 32'd0);
        q.delete();
        mok = 0;
        merr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_ready", {31'd0, in_ready}, 32'd1);
        drive_i(14);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the immediate-generation path: packs decoded instruction fields and a full 32-bit immediate into a legal RV32I instruction word.
- Checks the immediate for range and alignment per format.
- Buffers encoded words in a small FIFO with valid/ready handshakes on both sides.
- Used by the self-test instruction writer and the bench stimulus path to load instruction memory.

Parameters:
- DEPTH, 4, output FIFO entries (power of 2, ≥2).
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  encoder can accept the bundle this cycle.
- in_fmt  input  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- in_opcode  input  7  opcode copied to [6:0].
- in_rd  input  5  destination register.
- in_rs1  input  5  source register 1.
- in_rs2  input  5  source register 2.
- in_funct3  input  3  funct3.
- in_funct7  input  7  funct7 (R only).
- in_imm  input  32  full signed immediate (for U: the final value, low 12 bits zero).
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer takes the head.
- out_instr  output  32  encoded instruction at head.
- out_err  output  2  head error code: 0 ok, 1 bad fmt, 2 out of range, 3 misaligned.
- cnt_ok  output  CNT_W  saturating count of accepted ok bundles.
- cnt_err  output  CNT_W  saturating count of accepted error bundles.

Behaviour:
- Reset (async, rst_n=0): FIFO empty; out_valid=0, out_instr=0, out_err=0, cnt_ok=0, cnt_err=0. Entries in flight are discarded. in_ready=1 from the first edge after release.
- Accept: handshake when in_valid && in_ready at a rising edge. in_ready = !full; no same-cycle pass-through when full.
- Pop: handshake when out_valid && out_ready.
- Simultaneous push and pop (FIFO not full): both occur and occupancy is unchanged.
- Latency: a bundle accepted at edge N is visible at the head (if the FIFO was empty) with out_valid=1 after edge N. Registered FIFO only; encode logic is combinational on inputs.
- out_instr and out_err are stable while out_valid && !out_ready.
- Pointers wrap modulo DEPTH. A full flag or count distinguishes full from empty.
- Encoding (all formats: [6:0]=opcode; where present, rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20]):
  - R: funct7 at [31:25].
  - I: imm[11:0] at [31:20].
  - S: imm[11:5] at [31:25], imm[4:0] at [11:7].
  - B: imm[12] at [31], imm[10:5] at [30:25], imm[4:1] at [11:8], imm[11] at [7].
  - U: imm[31:12] at [31:12].
  - J: imm[20] at [31], imm[10:1] at [30:21], imm[11] at [20], imm[19:12] at [19:12].
- Checks (signed compare on in_imm; error priority: bad fmt > misaligned > range):
  - I/S: -2048..2047.
  - B: -4096..4094, imm[0]=0.
  - J: -1048576..1048574, imm[0]=0.
  - U: imm[11:0]=0, reported as misaligned otherwise.
  - R: imm ignored.
- Error bundles are still enqueued, with out_instr=0 and the error code. cnt_err increments; otherwise cnt_ok increments.
- Counters saturate at all-ones and never wrap.

Test Plan:
- I-type, opcode 0010011, rd=1, rs1=0, f3=0, imm=5 -> out_instr=0x00500093, out_err=0, one cycle after accept; cnt_ok=1.
- S-type, opcode 0100011, f3=2, rs1=1, rs2=2, imm=8 -> 0x0020A423. B-type, opcode 1100011, rs1=rs2=0, f3=0, imm=-4 -> 0xFE000EE3.
- J-type, opcode 1101111, rd=1, imm=2048 -> 0x001000EF. U-type, opcode 0110111, rd=5, imm=0x12345000 -> 0x123452B7.
- Errors:
  - B imm=3 -> err=3, instr=0.
  - I imm=2048 -> err=2.
  - fmt=7 -> err=1.
  - Result: cnt_err=3, cnt_ok unchanged.
- Hold out_ready=0 and push DEPTH bundles -> in_ready=0 after the 4th push; extra in_valid is ignored. Then assert out_ready with simultaneous push -> order is preserved across pointer wrap, with no loss or duplication.
- Assert rst_n=0 mid-stream with 3 entries queued -> out_valid=0 immediately (async), counters=0; after release, the next push emerges alone.
